wb_arbiter_rv32i: RTL and testbench
===================================

WB_ARBITER_RV32I -- requirements
Module: wb_arbiter_rv32i

Interface
REQ-001 The block SHALL use a single clock, clock; reset is synchronous and active-high, named reset.
REQ-002 Ports SHALL be:
- clock  in  1  global clock, all state updates on posedge
- reset  in  1  synchronous active-high reset
- alu_valid  in  1  ALU write-back request
- alu_ready  out  1  ALU request accepted this cycle
- alu_rd  in  5  ALU destination register
- alu_data  in  32  ALU write-back data
- mem_valid  in  1  load-unit write-back request
- mem_ready  out  1  load request accepted this cycle
- mem_rd  in  5  load destination register
- mem_data  in  32  load write-back data
- cu_rdwrite  out  1  register-file write enable
- rd_addr  out  5  register-file write address
- rd_in  out  32  register-file write data
- rs1_addr  in  5  decode read address 1, for the hazard check
- rs2_addr  in  5  decode read address 2, for the hazard check
- rs1_busy  out  1  rs1_addr has a write in flight
- rs2_busy  out  1  rs2_addr has a write in flight
- alu_wr_count  out  16  accepted ALU writes to nonzero rd
- mem_wr_count  out  16  accepted load writes to nonzero rd

Function
REQ-003 The block SHALL arbitrate two write-back sources onto one register-file write port and accept at most one request per cycle.
REQ-004 A handshake SHALL complete when valid and ready are both high at posedge.
- ready is combinational from valid and the arbiter state.
- A source SHALL hold its rd and data stable while valid is high and ready is low.
REQ-005 Arbitration SHALL be round-robin.
- Single valid source: that source is granted.
- Both valid: the source not granted most recently is granted.
- Neither valid: no grant, and last_grant is unchanged.
REQ-006 The output stage SHALL be registered with one-cycle latency: a request accepted at posedge N drives cu_rdwrite/rd_addr/rd_in during cycle N+1.
REQ-007 cu_rdwrite SHALL be high for exactly one cycle per accepted request with rd != 0.
REQ-008 A request with rd = 0 SHALL be accepted normally and dropped: cu_rdwrite stays 0, no counter increments, last_grant updates.
REQ-009 The output stage SHALL never stall, because the register file writes every posedge; ready depends only on arbitration.
REQ-010 When cu_rdwrite is 0, rd_addr and rd_in SHALL be 0.
REQ-011 rsX_busy SHALL be combinational and high when rsX_addr != 0 and any of these match rsX_addr:
- the output stage rd_addr while cu_rdwrite is 1;
- alu_rd while alu_valid is 1;
- mem_rd while mem_valid is 1.
REQ-012 rsX_busy SHALL be 0 for rsX_addr = 0 under all conditions.
REQ-013 Both sources valid with the same rd SHALL be written in grant order, one cycle apart; the later write wins in the register file.
REQ-014 The write counters SHALL increment by 1 on each accepted nonzero-rd write from their source and wrap from 0xFFFF to 0x0000.

Reset
REQ-015 While reset is high at posedge, the following SHALL be cleared:
- cu_rdwrite, rd_addr, rd_in = 0;
- alu_wr_count, mem_wr_count = 0;
- last_grant = ALU, so the load unit wins the first conflict after reset.
REQ-016 While reset is high, alu_ready and mem_ready SHALL be 0 and no request is accepted.
REQ-017 A reset asserted while the output stage holds a write SHALL discard that write: cu_rdwrite is 0 in the cycle after the reset edge.

Structure
REQ-018 A shared package SHALL hold:
- XLEN = 32 and REG_ADDR_W = 5;
- the source encoding SRC_ALU = 0, SRC_MEM = 1;
- the counter width WR_CNT_W = 16.
REQ-019 The round-robin grant logic SHALL be a sub-module rr_arbiter2 (2 requests, 2 one-hot grants, last-grant register, synchronous reset).

Verification
REQ-020 Reset followed by simultaneous alu(rd=5, data=0x11) and mem(rd=6, data=0x22):
- mem is accepted first and cu_rdwrite=1, rd_addr=6, rd_in=0x22 one cycle later;
- alu is accepted next and rd_addr=5, rd_in=0x11 the following cycle.
REQ-021 Both sources held valid for 6 cycles: grants strictly alternate, neither waits more than 1 cycle, and each counter = 3.
REQ-022 alu(rd=0, data=0xDEAD) alone: alu_ready=1, cu_rdwrite stays 0 and alu_wr_count is unchanged.
REQ-023 Hazard check:
- alu_valid with rd=7 and rs1_addr=7 gives rs1_busy=1 that cycle and the next;
- rs2_addr=0 while mem_rd=0 and mem_valid=1 gives rs2_busy=0.
REQ-024 Reset asserted the cycle after accepting mem(rd=9): cu_rdwrite=0 the following cycle, and the counters read 0.
REQ-025 Preload alu_wr_count to 0xFFFF through 65535 accepted writes, then one more write: the counter reads 0x0000.

Source files
------------

// File: rtl/wb_arbiter_rv32i_pkg.sv
// Shared widths, source encoding and helpers for the write-back arbiter.
// Source codes double as grant-vector bit positions.
package wb_arbiter_rv32i_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int WR_CNT_W   = 16;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } src_e;

  typedef struct packed {
    logic                  we;
    logic [REG_ADDR_W-1:0] addr;
    logic [XLEN-1:0]       data;
  } wb_out_t;

  // True when a pending or in-flight write targets the decode read address.
  function automatic logic addr_hit(input logic [REG_ADDR_W-1:0] rs,
                                    input logic                  pending,
                                    input logic [REG_ADDR_W-1:0] rd);
    return pending && (rd == rs);
  endfunction

endpackage

// File: rtl/wb_arbiter_rv32i_rr_arbiter2.sv
// Two-requester round-robin arbiter with a registered last-grant pointer.
// gnt is combinational; nothing is granted while reset is high.
module rr_arbiter2
  import wb_arbiter_rv32i_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  src_e last_grant;

  always_comb begin
    gnt = 2'b00;
    if (!reset) begin
      if (req == 2'b11) begin
        // On conflict the source that did not win last time goes first.
        gnt = (last_grant == SRC_ALU) ? 2'b10 : 2'b01;
      end else begin
        gnt = req;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant <= SRC_ALU;
    end else if (gnt[SRC_MEM]) begin
      last_grant <= SRC_MEM;
    end else if (gnt[SRC_ALU]) begin
      last_grant <= SRC_ALU;
    end
  end

endmodule

// File: rtl/wb_arbiter_rv32i.sv
// Merges ALU and load-unit write-backs onto one register-file write port,
// with a one-cycle registered output stage and decode hazard flags.
module wb_arbiter_rv32i
  import wb_arbiter_rv32i_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]       alu_data,
  input  logic                  mem_valid,
  output logic                  mem_ready,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic [XLEN-1:0]       mem_data,
  output logic                  cu_rdwrite,
  output logic [REG_ADDR_W-1:0] rd_addr,
  output logic [XLEN-1:0]       rd_in,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  output logic [WR_CNT_W-1:0]   alu_wr_count,
  output logic [WR_CNT_W-1:0]   mem_wr_count
);

  // Handshake: a source presents valid with stable rd/data; the transfer
  // happens at the posedge where valid && ready. ready depends only on the
  // arbitration decision, because the output stage never stalls.
  logic [1:0] gnt;
  wb_out_t    out_q;

  rr_arbiter2 u_rr (
    .clock (clock),
    .reset (reset),
    .req   ({mem_valid, alu_valid}),
    .gnt   (gnt)
  );

  assign alu_ready = gnt[SRC_ALU];
  assign mem_ready = gnt[SRC_MEM];

  always_ff @(posedge clock) begin
    if (reset) begin
      out_q        <= '0;
      alu_wr_count <= '0;
      mem_wr_count <= '0;
    end else begin
      out_q <= '0;
      // Writes to x0 are accepted but never reach the register file.
      if (gnt[SRC_ALU]) begin
        if (alu_rd != '0) begin
          out_q        <= '{we: 1'b1, addr: alu_rd, data: alu_data};
          alu_wr_count <= alu_wr_count + WR_CNT_W'(1);
        end
      end else if (gnt[SRC_MEM]) begin
        if (mem_rd != '0) begin
          out_q        <= '{we: 1'b1, addr: mem_rd, data: mem_data};
          mem_wr_count <= mem_wr_count + WR_CNT_W'(1);
        end
      end
    end
  end

  assign cu_rdwrite = out_q.we;
  assign rd_addr    = out_q.addr;
  assign rd_in      = out_q.data;

  assign rs1_busy = (rs1_addr != '0) &&
                    (addr_hit(rs1_addr, cu_rdwrite, rd_addr) ||
                     addr_hit(rs1_addr, alu_valid, alu_rd)   ||
                     addr_hit(rs1_addr, mem_valid, mem_rd));

  assign rs2_busy = (rs2_addr != '0) &&
                    (addr_hit(rs2_addr, cu_rdwrite, rd_addr) ||
                     addr_hit(rs2_addr, alu_valid, alu_rd)   ||
                     addr_hit(rs2_addr, mem_valid, mem_rd));

endmodule

// File: tb/tb_wb_arbiter_rv32i.sv
// Self-checking bench for wb_arbiter_rv32i: a cycle model feeds an expected
// queue that is drained every negedge, plus directed scenario tasks.
module tb_wb_arbiter_rv32i;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        alu_valid = 1'b0, mem_valid = 1'b0;
  logic        alu_ready, mem_ready;
  logic [4:0]  alu_rd = '0, mem_rd = '0;
  logic [31:0] alu_data = '0, mem_data = '0;
  logic        cu_rdwrite;
  logic [4:0]  rd_addr;
  logic [31:0] rd_in;
  logic [4:0]  rs1_addr = '0, rs2_addr = '0;
  logic        rs1_busy, rs2_busy;
  logic [15:0] alu_wr_count, mem_wr_count;

  int checks = 0;
  int errors = 0;

  // Expected output stage per cycle: {we, addr[4:0], data[31:0]}
  logic [37:0] exp_q[$];

  // Model state: m_last 0 = ALU granted last, 1 = load unit granted last
  logic        m_last = 1'b0;
  logic [15:0] m_alu_cnt = '0, m_mem_cnt = '0;
  logic        m_alu_acc = 1'b0, m_mem_acc = 1'b0;
  logic        exp_alu_ready, exp_mem_ready;

  wb_arbiter_rv32i dut (
    .clock        (clock),
    .reset        (reset),
    .alu_valid    (alu_valid),
    .alu_ready    (alu_ready),
    .alu_rd       (alu_rd),
    .alu_data     (alu_data),
    .mem_valid    (mem_valid),
    .mem_ready    (mem_ready),
    .mem_rd       (mem_rd),
    .mem_data     (mem_data),
    .cu_rdwrite   (cu_rdwrite),
    .rd_addr      (rd_addr),
    .rd_in        (rd_in),
    .rs1_addr     (rs1_addr),
    .rs2_addr     (rs2_addr),
    .rs1_busy     (rs1_busy),
    .rs2_busy     (rs2_busy),
    .alu_wr_count (alu_wr_count),
    .mem_wr_count (mem_wr_count)
  );

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  always_comb begin
    exp_alu_ready = 1'b0;
    exp_mem_ready = 1'b0;
    if (!reset) begin
      if (alu_valid && mem_valid) begin
        exp_alu_ready = m_last;
        exp_mem_ready = !m_last;
      end else begin
        exp_alu_ready = alu_valid;
        exp_mem_ready = mem_valid;
      end
    end
  end

  always @(posedge clock) begin
    logic [37:0] entry;
    entry = '0;
    if (reset) begin
      m_last    = 1'b0;
      m_alu_cnt = '0;
      m_mem_cnt = '0;
      m_alu_acc = 1'b0;
      m_mem_acc = 1'b0;
    end else begin
      m_alu_acc = exp_alu_ready;
      m_mem_acc = exp_mem_ready;
      if (m_alu_acc) begin
        m_last = 1'b0;
        if (alu_rd != 5'd0) begin
          entry     = {1'b1, alu_rd, alu_data};
          m_alu_cnt = m_alu_cnt + 16'd1;
        end
      end else if (m_mem_acc) begin
        m_last = 1'b1;
        if (mem_rd != 5'd0) begin
          entry     = {1'b1, mem_rd, mem_data};
          m_mem_cnt = m_mem_cnt + 16'd1;
        end
      end
    end
    exp_q.push_back(entry);
  end

  // ---------------- scoreboard ----------------
  always @(negedge clock) begin
    logic [37:0] e;
    logic        b1, b2;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({cu_rdwrite, rd_addr, rd_in} !== e) begin
        errors++;
        $display("FAIL wb_out got we=%0b rd=%0d data=%h expected we=%0b rd=%0d data=%h",
                 cu_rdwrite, rd_addr, rd_in, e[37], e[36:32], e[31:0]);
      end
      checks++;
      if ({alu_ready, mem_ready} !== {exp_alu_ready, exp_mem_ready}) begin
        errors++;
        $display("FAIL ready got alu=%0b mem=%0b expected alu=%0b mem=%0b",
                 alu_ready, mem_ready, exp_alu_ready, exp_mem_ready);
      end
      checks++;
      if ({alu_wr_count, mem_wr_count} !== {m_alu_cnt, m_mem_cnt}) begin
        errors++;
        $display("FAIL counters got alu=%h mem=%h expected alu=%h mem=%h",
                 alu_wr_count, mem_wr_count, m_alu_cnt, m_mem_cnt);
      end
      b1 = (rs1_addr != 0) && ((e[37] && e[36:32] == rs1_addr) ||
                               (alu_valid && alu_rd == rs1_addr) ||
                               (mem_valid && mem_rd == rs1_addr));
      b2 = (rs2_addr != 0) && ((e[37] && e[36:32] == rs2_addr) ||
                               (alu_valid && alu_rd == rs2_addr) ||
                               (mem_valid && mem_rd == rs2_addr));
      checks++;
      if ({rs1_busy, rs2_busy} !== {b1, b2}) begin
        errors++;
        $display("FAIL busy got rs1=%0b rs2=%0b expected rs1=%0b rs2=%0b",
                 rs1_busy, rs2_busy, b1, b2);
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    alu_rd    = '0;
    mem_rd    = '0;
    alu_data  = '0;
    mem_data  = '0;
    rs1_addr  = '0;
    rs2_addr  = '0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset     = 1'b1;
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h1;
    mem_valid = 1'b1; mem_rd = 5'd4; mem_data = 32'h2;
    step();
    step();
    @(negedge clock);
    checks++;
    if ({alu_ready, mem_ready} !== 2'b00) begin
      errors++;
      $display("FAIL reset_ready got %b expected 00", {alu_ready, mem_ready});
    end
    checks++;
    if ({cu_rdwrite, rd_addr, rd_in, alu_wr_count, mem_wr_count} !== '0) begin
      errors++;
      $display("FAIL reset_state got we=%0b rd=%0d data=%h cnt=%h/%h expected all zero",
               cu_rdwrite, rd_addr, rd_in, alu_wr_count, mem_wr_count);
    end
    step();
    idle_inputs();
  endtask

  task automatic test_first_conflict();
    reset     = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h11;
    mem_valid = 1'b1; mem_rd = 5'd6; mem_data = 32'h22;
    @(negedge clock);
    checks++;
    if ({alu_ready, mem_ready} !== 2'b01) begin
      errors++;
      $display("FAIL first_conflict_grant got alu=%0b mem=%0b expected alu=0 mem=1",
               alu_ready, mem_ready);
    end
    step();
    mem_valid = 1'b0;
    @(negedge clock);
    checks++;
    if ({cu_rdwrite, rd_addr, rd_in, alu_ready} !== {1'b1, 5'd6, 32'h22, 1'b1}) begin
      errors++;
      $display("FAIL first_conflict_mem got we=%0b rd=%0d data=%h alu_ready=%0b expected 1/6/22/1",
               cu_rdwrite, rd_addr, rd_in, alu_ready);
    end
    step();
    alu_valid = 1'b0;
    @(negedge clock);
    checks++;
    if ({cu_rdwrite, rd_addr, rd_in} !== {1'b1, 5'd5, 32'h11}) begin
      errors++;
      $display("FAIL first_conflict_alu got we=%0b rd=%0d data=%h expected 1/5/11",
               cu_rdwrite, rd_addr, rd_in);
    end
    step();
  endtask

  task automatic test_alternate();
    reset = 1'b1;
    step();
    reset = 1'b0;
    // Same destination on both sides: grant order decides the final value.
    alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'hA0A0_0001;
    mem_valid = 1'b1; mem_rd = 5'd10; mem_data = 32'hB0B0_0002;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      checks++;
      if ({alu_ready, mem_ready} !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
        errors++;
        $display("FAIL alternate_grant cycle %0d got alu=%0b mem=%0b expected %s",
                 i, alu_ready, mem_ready, (i % 2 == 0) ? "mem" : "alu");
      end
      step();
    end
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    @(negedge clock);
    checks++;
    if ({alu_wr_count, mem_wr_count} !== {16'd3, 16'd3}) begin
      errors++;
      $display("FAIL alternate_counts got alu=%0d mem=%0d expected 3/3",
               alu_wr_count, mem_wr_count);
    end
    step();
  endtask

  task automatic test_rd_zero();
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hDEAD;
    @(negedge clock);
    checks++;
    if (alu_ready !== 1'b1) begin
      errors++;
      $display("FAIL rd_zero_ready got %0b expected 1", alu_ready);
    end
    step();
    alu_valid = 1'b0;
    @(negedge clock);
    checks++;
    if ({cu_rdwrite, alu_wr_count} !== {1'b0, 16'd3}) begin
      errors++;
      $display("FAIL rd_zero_drop got we=%0b alu_cnt=%0d expected we=0 alu_cnt=3",
               cu_rdwrite, alu_wr_count);
    end
    step();
  endtask

  task automatic test_hazard();
    rs1_addr  = 5'd7;
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h77;
    @(negedge clock);
    checks++;
    if (rs1_busy !== 1'b1) begin
      errors++;
      $display("FAIL hazard_pending got %0b expected 1", rs1_busy);
    end
    step();
    alu_valid = 1'b0;
    @(negedge clock);
    checks++;
    if (rs1_busy !== 1'b1) begin
      errors++;
      $display("FAIL hazard_inflight got %0b expected 1", rs1_busy);
    end
    step();
    @(negedge clock);
    checks++;
    if (rs1_busy !== 1'b0) begin
      errors++;
      $display("FAIL hazard_clear got %0b expected 0", rs1_busy);
    end
    rs1_addr  = 5'd0;
    step();
    rs2_addr  = 5'd0;
    mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'h5;
    @(negedge clock);
    checks++;
    if ({rs2_busy, mem_ready} !== 2'b01) begin
      errors++;
      $display("FAIL hazard_x0 got busy=%0b mem_ready=%0b expected 0/1", rs2_busy, mem_ready);
    end
    step();
    idle_inputs();
  endtask

  task automatic test_reset_discard();
    mem_valid = 1'b1; mem_rd = 5'd9; mem_data = 32'h9999;
    step();
    reset     = 1'b1;
    mem_valid = 1'b0;
    @(negedge clock);
    checks++;
    if ({cu_rdwrite, rd_addr} !== {1'b1, 5'd9}) begin
      errors++;
      $display("FAIL discard_held got we=%0b rd=%0d expected 1/9", cu_rdwrite, rd_addr);
    end
    step();
    @(negedge clock);
    checks++;
    if ({cu_rdwrite, alu_wr_count, mem_wr_count} !== '0) begin
      errors++;
      $display("FAIL discard_cleared got we=%0b cnt=%h/%h expected 0/0000/0000",
               cu_rdwrite, alu_wr_count, mem_wr_count);
    end
    step();
    reset = 1'b0;
  endtask

  task automatic test_random(input int n);
    for (int i = 0; i < n; i++) begin
      // A stalled source keeps its request unchanged until accepted.
      if (!alu_valid || m_alu_acc) begin
        alu_valid = 1'($urandom_range(0, 1));
        alu_rd    = 5'($urandom_range(0, 31));
        alu_data  = $urandom;
      end
      if (!mem_valid || m_mem_acc) begin
        mem_valid = 1'($urandom_range(0, 1));
        mem_rd    = 5'($urandom_range(0, 31));
        mem_data  = $urandom;
      end
      rs1_addr = 5'($urandom_range(0, 31));
      rs2_addr = 5'($urandom_range(0, 31));
      step();
    end
    idle_inputs();
    step();
  endtask

  task automatic test_wrap();
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 65535; i++) begin
      alu_valid = 1'b1;
      alu_rd    = 5'($urandom_range(1, 31));
      alu_data  = $urandom;
      step();
    end
    checks++;
    if (alu_wr_count !== 16'hFFFF) begin
      errors++;
      $display("FAIL wrap_preload got %h expected ffff", alu_wr_count);
    end
    step();
    alu_valid = 1'b0;
    checks++;
    if (alu_wr_count !== 16'h0000) begin
      errors++;
      $display("FAIL wrap_rollover got %h expected 0000", alu_wr_count);
    end
    step();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_first_conflict();
    test_alternate();
    test_rd_zero();
    test_hazard();
    test_reset_discard();
    test_random(400);
    test_wrap();
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
